// File: rtl/munoc_ordered_gather_if.sv
// munoc_ordered_gather_if
// Bundles the per-lane write streams and the single ordered read stream of
// munoc_ordered_gather.
//   lane_wready   : per-lane FIFO not full (collector -> producers)
//   lane_wrequest : per-lane write strobe (producers -> collector)
//   lane_wdata    : lane i data in bits [BW_DATA*i +: BW_DATA]
//   rready        : output beat available (collector -> consumer)
//   rrequest      : consumer takes the beat (consumer -> collector)
//   rdata         : output beat
//   cur_lane      : one-hot lane currently selected by the rotation pointer
// Modport "slave" is the collector side; "master" is the producer/consumer side.
interface munoc_ordered_gather_if #(
  parameter int BW_DATA  = 8,
  parameter int NUM_LANE = 4
);
  logic [NUM_LANE-1:0]         lane_wready;
  logic [NUM_LANE-1:0]         lane_wrequest;
  logic [NUM_LANE*BW_DATA-1:0] lane_wdata;
  logic                        rready;
  logic                        rrequest;
  logic [BW_DATA-1:0]          rdata;
  logic [NUM_LANE-1:0]         cur_lane;

  modport master (
    input  lane_wready, rready, rdata, cur_lane,
    output lane_wrequest, lane_wdata, rrequest
  );

  modport slave (
    output lane_wready, rready, rdata, cur_lane,
    input  lane_wrequest, lane_wdata, rrequest
  );
endinterface

// File: rtl/munoc_ordered_gather.sv
// munoc_ordered_gather
// Ordered N-to-1 stream collector. Each lane feeds its own DEPTH-entry FIFO;
// the output drains the FIFOs in strict lane rotation 0,1,..,NUM_LANE-1,0,..
// An empty lane at the rotation pointer stalls the output; lanes are never
// skipped, which restores the order produced by the upstream distributor.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (FIFOs emptied, pointer to lane 0)
//   init : restart rotation at lane 0 on the next edge (FIFO contents kept)
//   bus  : munoc_ordered_gather_if.slave (lane write streams, ordered read stream)
// Build option:
//   MUNOC_ORDERED_GATHER_OUTPUT_REG_EN - adds a 1-entry output register between
//   the lane mux and rdata/rready (2-cycle latency, still 1 beat/cycle).
module munoc_ordered_gather #(
  parameter int BW_DATA  = 8,
  parameter int NUM_LANE = 4,
  parameter int DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  munoc_ordered_gather_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [BW_DATA-1:0]  mem_q     [NUM_LANE][DEPTH];
  logic [BW_DATA-1:0]  mem_d     [NUM_LANE][DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q  [NUM_LANE];
  logic [PTR_W-1:0]    wr_ptr_d  [NUM_LANE];
  logic [PTR_W-1:0]    rd_ptr_q  [NUM_LANE];
  logic [PTR_W-1:0]    rd_ptr_d  [NUM_LANE];
  logic [CNT_W-1:0]    count_q   [NUM_LANE];
  logic [CNT_W-1:0]    count_d   [NUM_LANE];
  logic [NUM_LANE-1:0] cur_q;
  logic [NUM_LANE-1:0] cur_d;

  logic [NUM_LANE-1:0] full;
  logic                mux_valid;
  logic [BW_DATA-1:0]  mux_head;
  logic                mux_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  // Lane status and the head of the lane under the rotation pointer.
  // cur_q is one-hot, so OR-ing the selected heads acts as a mux.
  always_comb begin
    mux_valid = 1'b0;
    mux_head  = '0;
    full      = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      full[i] = (count_q[i] == CNT_W'(DEPTH));
      if (cur_q[i]) begin
        mux_valid = mux_valid | (count_q[i] != '0);
        mux_head  = mux_head | mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  assign bus.lane_wready = ~full;
  assign bus.cur_lane    = cur_q;

`ifdef MUNOC_ORDERED_GATHER_OUTPUT_REG_EN
  logic               out_valid_q;
  logic               out_valid_d;
  logic [BW_DATA-1:0] out_data_q;
  logic [BW_DATA-1:0] out_data_d;
  logic               out_load;

  // The register refills whenever it is empty or being drained; the lane
  // pop and pointer rotation happen only when a beat actually moves in.
  always_comb begin
    out_load   = !out_valid_q | bus.rrequest;
    mux_pop    = out_load & mux_valid;
    out_valid_d = out_load ? mux_valid : out_valid_q;
    out_data_d = out_data_q;
    if (mux_pop) out_data_d = mux_head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.rready = out_valid_q;
  assign bus.rdata  = out_valid_q ? out_data_q : '0;
`else
  assign mux_pop    = mux_valid & bus.rrequest;
  assign bus.rready = mux_valid;
  assign bus.rdata  = mux_valid ? mux_head : '0;
`endif

  // Next-state for FIFOs and rotation pointer. A full lane refuses writes
  // even if it is popped in the same cycle (readiness is state-only).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cur_d    = cur_q;
    for (int i = 0; i < NUM_LANE; i++) begin
      logic push_i;
      logic pop_i;
      push_i = bus.lane_wrequest[i] & !full[i];
      pop_i  = mux_pop & cur_q[i];
      if (push_i) begin
        mem_d[i][wr_ptr_q[i]] = bus.lane_wdata[BW_DATA*i +: BW_DATA];
        wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      end
      if (pop_i) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      if (push_i && !pop_i) count_d[i] = count_q[i] + CNT_W'(1);
      else if (!push_i && pop_i) count_d[i] = count_q[i] - CNT_W'(1);
    end
    if (mux_pop) begin
      cur_d = '0;
      for (int i = 0; i < NUM_LANE; i++) cur_d[(i + 1) % NUM_LANE] = cur_q[i];
    end
    // init wins over rotation; a coinciding pop still completes.
    if (init) cur_d = NUM_LANE'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= NUM_LANE'(1);
      for (int i = 0; i < NUM_LANE; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      cur_q    <= cur_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy counters define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
